// File: rtl/spm_vec.sv
// -----------------------------------------------------------------------------
// spm_vec -- streaming signed dot-product engine (neuron MAC stage).
//
// Takes LANES signed element pairs per accepted beat. The per-beat sums are
// accumulated over BEATS = VEC_LEN/LANES beats. The finished dot product is
// presented through a single valid/ready output register.
//
// Optional feature macro: SPM_VEC_SAT_EN
//   undefined : q is the low OUT_W bits of the accumulated sum (wraps).
//   defined   : q saturates to the signed OUT_W range, and the extra output
//               sat_flag marks a clamped result.
//
// Ports:
//   clk        rising-edge clock
//   areset     asynchronous reset, active-low
//   clr        synchronous flush of a partial accumulation (blocks input)
//   in_valid   beat present on a_vec / b_vec
//   in_ready   engine can accept a beat (independent of in_valid)
//   a_vec      LANES packed signed elements, lane i = [i*DATA_W +: DATA_W]
//   b_vec      same packing as a_vec
//   out_valid  q holds a completed result
//   out_ready  consumer accepts q
//   q          signed dot product
//   busy       a partial vector is in progress
//   sat_flag   (SPM_VEC_SAT_EN only) delivered q was clamped
// -----------------------------------------------------------------------------
module spm_vec #(
  parameter int DATA_W  = 32,
  parameter int LANES   = 2,
  parameter int VEC_LEN = 8,
  parameter int OUT_W   = 32,
  parameter int ACC_W   = 2*DATA_W + $clog2(VEC_LEN) + 1
) (
  input  logic                    clk,
  input  logic                    areset,
  input  logic                    clr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] a_vec,
  input  logic [LANES*DATA_W-1:0] b_vec,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] q,
  output logic                    busy
`ifdef SPM_VEC_SAT_EN
  ,
  output logic                    sat_flag
`endif
);

  localparam int BEATS = VEC_LEN / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        beat_cnt;

  logic signed [ACC_W-1:0] prod_ext [LANES];
  logic signed [ACC_W-1:0] beat_sum;
  logic signed [ACC_W-1:0] total;
  logic [OUT_W-1:0]        q_next;
  logic                    last_beat;
  logic                    accept;
  logic                    final_accept;

  // One full-width signed product per lane. The operands are widened
  // explicitly, so the multiply keeps all 2*DATA_W result bits.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [2*DATA_W-1:0] a_ext;
    logic signed [2*DATA_W-1:0] b_ext;
    logic signed [2*DATA_W-1:0] prod;

    assign a_ext = {{DATA_W{a_vec[i*DATA_W + DATA_W-1]}}, a_vec[i*DATA_W +: DATA_W]};
    assign b_ext = {{DATA_W{b_vec[i*DATA_W + DATA_W-1]}}, b_vec[i*DATA_W +: DATA_W]};
    assign prod  = a_ext * b_ext;
    assign prod_ext[i] = ACC_W'(prod);
  end

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      beat_sum = beat_sum + prod_ext[i];
    end
  end

  assign total = acc + beat_sum;

`ifdef SPM_VEC_SAT_EN
  logic sat_next;

  // total fits in OUT_W signed bits exactly when the bits from OUT_W-1 upward
  // are all copies of the sign.
  always_comb begin
    q_next   = total[OUT_W-1:0];
    sat_next = 1'b0;
    if (!(&total[ACC_W-1:OUT_W-1]) && (|total[ACC_W-1:OUT_W-1])) begin
      sat_next = 1'b1;
      q_next   = total[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end
`else
  logic unused_total_hi;

  assign q_next          = total[OUT_W-1:0];
  assign unused_total_hi = ^(total >> OUT_W);
`endif

  assign last_beat = (beat_cnt == LAST_BEAT);

  // Only the final beat must wait for a held result; clr blocks all input.
  assign in_ready     = !clr && !(last_beat && out_valid && !out_ready);
  assign accept       = in_valid && in_ready;
  assign final_accept = accept && last_beat;
  assign busy         = (beat_cnt != '0);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the clock edge.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      acc      <= '0;
      beat_cnt <= '0;
    end else if (clr) begin
      acc      <= '0;
      beat_cnt <= '0;
    end else if (accept) begin
      if (last_beat) begin
        acc      <= '0;
        beat_cnt <= '0;
      end else begin
        acc      <= total;
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
    end
  end

  // Output register: holds while stalled, and is reloaded by a new final beat
  // even in the same cycle that the old result is consumed.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      out_valid <= 1'b0;
      q         <= '0;
`ifdef SPM_VEC_SAT_EN
      sat_flag  <= 1'b0;
`endif
    end else if (final_accept) begin
      out_valid <= 1'b1;
      q         <= q_next;
`ifdef SPM_VEC_SAT_EN
      sat_flag  <= sat_next;
`endif
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spm_vec.sv
// -----------------------------------------------------------------------------
// tb_spm_vec -- directed, table-driven bench for spm_vec
// (DATA_W=8, LANES=2, VEC_LEN=4, OUT_W=16).
//
// Each table row drives one clock cycle. in_ready is checked during that
// cycle. out_valid, q, busy (and sat_flag) are checked just after the closing
// edge. A hand-written sequence covers asynchronous reset mid-operation.
// -----------------------------------------------------------------------------
module tb_spm_vec;

  localparam int DATA_W  = 8;
  localparam int LANES   = 2;
  localparam int VEC_LEN = 4;
  localparam int OUT_W   = 16;

`ifdef SPM_VEC_SAT_EN
  localparam int OV_Q = 32767;
  localparam bit OV_S = 1'b1;
`else
  localparam int OV_Q = -1020;
  localparam bit OV_S = 1'b0;
`endif

  typedef struct {
    bit clr;
    bit iv;
    bit ordy;
    int a0, a1, b0, b1;
    bit e_ir;
    bit e_ov;
    int e_q;
    bit e_busy;
    bit e_sat;
  } row_t;

  logic                    clk;
  logic                    areset;
  logic                    clr;
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*DATA_W-1:0] a_vec;
  logic [LANES*DATA_W-1:0] b_vec;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] q;
  logic                    busy;
`ifdef SPM_VEC_SAT_EN
  logic                    sat_flag;
`endif

  int n_vec = 0;
  int n_err = 0;
  row_t tbl[$];

  spm_vec #(
    .DATA_W (DATA_W),
    .LANES  (LANES),
    .VEC_LEN(VEC_LEN),
    .OUT_W  (OUT_W)
  ) dut (
    .clk      (clk),
    .areset   (areset),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_vec    (a_vec),
    .b_vec    (b_vec),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .q        (q),
    .busy     (busy)
`ifdef SPM_VEC_SAT_EN
    ,
    .sat_flag (sat_flag)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int idx, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  function automatic row_t mk(input bit c, input bit iv, input bit ordy,
                              input int a0, input int a1, input int b0, input int b1,
                              input bit e_ir, input bit e_ov, input int e_q,
                              input bit e_busy, input bit e_sat);
    row_t r;
    r.clr = c;  r.iv = iv;  r.ordy = ordy;
    r.a0 = a0;  r.a1 = a1;  r.b0 = b0;  r.b1 = b1;
    r.e_ir = e_ir;  r.e_ov = e_ov;  r.e_q = e_q;
    r.e_busy = e_busy;  r.e_sat = e_sat;
    return r;
  endfunction

  task automatic apply_row(input row_t r, input int idx);
    @(negedge clk);
    clr       = r.clr;
    in_valid  = r.iv;
    out_ready = r.ordy;
    a_vec     = {8'(r.a1), 8'(r.a0)};
    b_vec     = {8'(r.b1), 8'(r.b0)};
    #1;
    check("in_ready", idx, int'(in_ready), int'(r.e_ir));
    @(posedge clk);
    #1;
    check("out_valid", idx, int'(out_valid), int'(r.e_ov));
    check("q", idx, int'(q), r.e_q);
    check("busy", idx, int'(busy), int'(r.e_busy));
`ifdef SPM_VEC_SAT_EN
    check("sat_flag", idx, int'(sat_flag), int'(r.e_sat));
`endif
  endtask

  initial begin
    areset    = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a_vec     = '0;
    b_vec     = '0;

    //                clr iv or   a0  a1  b0  b1   ir ov  q    busy sat
    // reset state, basic vector (39 + -4 = 35), one-cycle out_valid
    tbl.push_back(mk(0, 0, 1,    0,  0,  0,  0,   1, 0,   0,  0, 0));
    tbl.push_back(mk(0, 1, 1,    3,  4,  5,  6,   1, 0,   0,  1, 0));
    tbl.push_back(mk(0, 1, 1,   -2,  1,  7, 10,   1, 1,  35,  0, 0));
    tbl.push_back(mk(0, 0, 1,    0,  0,  0,  0,   1, 0,  35,  0, 0));
    // overflow: 4 * 127*127 = 64516
    tbl.push_back(mk(0, 1, 1,  127,127,127,127,   1, 0,  35,  1, 0));
    tbl.push_back(mk(0, 1, 1,  127,127,127,127,   1, 1, OV_Q, 0, OV_S));
    tbl.push_back(mk(0, 0, 1,    0,  0,  0,  0,   1, 0, OV_Q, 0, OV_S));
    // mixed signs: (-5 - 6) + (0 - 4) = -15
    tbl.push_back(mk(0, 1, 1,   -1,  2,  5, -3,   1, 0, OV_Q, 1, OV_S));
    tbl.push_back(mk(0, 1, 1,    0, -4,  9,  1,   1, 1, -15,  0, 0));
    tbl.push_back(mk(0, 0, 1,    0,  0,  0,  0,   1, 0, -15,  0, 0));
    // backpressure: 35 held, next vector (2 + 12 = 14) stalls on its final beat
    tbl.push_back(mk(0, 1, 0,    3,  4,  5,  6,   1, 0, -15,  1, 0));
    tbl.push_back(mk(0, 1, 0,   -2,  1,  7, 10,   1, 1,  35,  0, 0));
    tbl.push_back(mk(0, 1, 0,    1,  1,  1,  1,   1, 1,  35,  1, 0));
    tbl.push_back(mk(0, 1, 0,    2,  2,  3,  3,   0, 1,  35,  1, 0));
    tbl.push_back(mk(0, 1, 1,    2,  2,  3,  3,   1, 1,  14,  0, 0));
    tbl.push_back(mk(0, 0, 1,    0,  0,  0,  0,   1, 0,  14,  0, 0));
    // flush: partial 162 discarded, beat under clr is refused
    tbl.push_back(mk(0, 1, 1,    9,  9,  9,  9,   1, 0,  14,  1, 0));
    tbl.push_back(mk(1, 1, 1,    1,  1,  1,  1,   0, 0,  14,  0, 0));
    tbl.push_back(mk(0, 1, 1,    3,  4,  5,  6,   1, 0,  14,  1, 0));
    tbl.push_back(mk(0, 1, 1,   -2,  1,  7, 10,   1, 1,  35,  0, 0));
    tbl.push_back(mk(0, 0, 1,    0,  0,  0,  0,   1, 0,  35,  0, 0));
    // clr with a result pending: q/out_valid survive, partial is dropped
    tbl.push_back(mk(0, 1, 0,    1,  1,  1,  1,   1, 0,  35,  1, 0));
    tbl.push_back(mk(0, 1, 0,    2,  2,  3,  3,   1, 1,  14,  0, 0));
    tbl.push_back(mk(0, 1, 0,    3,  4,  5,  6,   1, 1,  14,  1, 0));
    tbl.push_back(mk(1, 0, 0,    0,  0,  0,  0,   0, 1,  14,  0, 0));
    tbl.push_back(mk(0, 0, 1,    0,  0,  0,  0,   1, 0,  14,  0, 0));
    // gapped basic vector: three idle cycles between beats
    tbl.push_back(mk(0, 1, 1,    3,  4,  5,  6,   1, 0,  14,  1, 0));
    tbl.push_back(mk(0, 0, 1,    0,  0,  0,  0,   1, 0,  14,  1, 0));
    tbl.push_back(mk(0, 0, 1,    0,  0,  0,  0,   1, 0,  14,  1, 0));
    tbl.push_back(mk(0, 0, 1,    0,  0,  0,  0,   1, 0,  14,  1, 0));
    tbl.push_back(mk(0, 1, 1,   -2,  1,  7, 10,   1, 1,  35,  0, 0));
    tbl.push_back(mk(0, 0, 1,    0,  0,  0,  0,   1, 0,  35,  0, 0));

    repeat (2) @(negedge clk);
    areset = 1'b1;

    foreach (tbl[i]) apply_row(tbl[i], i);

    // Asynchronous reset with a result pending and a partial vector in flight.
    apply_row(mk(0, 1, 0,  1, 1, 1, 1,   1, 0, 35, 1, 0), 100);
    apply_row(mk(0, 1, 0,  2, 2, 3, 3,   1, 1, 14, 0, 0), 101);
    apply_row(mk(0, 1, 0,  3, 4, 5, 6,   1, 1, 14, 1, 0), 102);
    #2;
    areset = 1'b0;
    #1;
    check("rst out_valid", 103, int'(out_valid), 0);
    check("rst q", 103, int'(q), 0);
    check("rst busy", 103, int'(busy), 0);
    check("rst in_ready", 103, int'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    areset   = 1'b1;
    // The partial beat (39) must be gone: the basic vector gives 35 again.
    apply_row(mk(0, 1, 1,  3, 4, 5, 6,   1, 0,  0, 1, 0), 104);
    apply_row(mk(0, 1, 1, -2, 1, 7, 10,  1, 1, 35, 0, 0), 105);
    apply_row(mk(0, 0, 1,  0, 0, 0, 0,   1, 0, 35, 0, 0), 106);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spm_vec.md
Name: spm_vec

Overview:
- Parametrised streaming dot-product engine; successor to the fixed two-term scalar product module (q = a0*b0 + a1*b1).
- Computes the signed dot product of two VEC_LEN-element vectors.
- Consumes LANES element pairs per accepted beat and accumulates over VEC_LEN/LANES beats.
- Presents the result through a valid/ready output register; used as the neuron MAC stage of the ANN datapath.

Parameters:
- DATA_W, 32, signed element width of a and b.
- LANES, 2, element pairs (multipliers) per beat; must be >= 1.
- VEC_LEN, 8, elements per vector; must be a multiple of LANES.
- OUT_W, 32, width of result q.
- ACC_W, 2*DATA_W+$clog2(VEC_LEN)+1, internal accumulator width; must be >= OUT_W.

Ports:
- clk  in  1  rising-edge clock.
- areset  in  1  asynchronous reset, active-low (0 = reset).
- clr  in  1  synchronous flush: discard partial accumulation.
- in_valid  in  1  beat present on a_vec/b_vec.
- in_ready  out  1  engine can accept a beat.
- a_vec  in  LANES*DATA_W  packed signed elements; lane i = bits [i*DATA_W +: DATA_W].
- b_vec  in  LANES*DATA_W  packed signed elements, same packing as a_vec.
- out_valid  out  1  q holds a completed result.
- out_ready  in  1  consumer accepts q.
- q  out  OUT_W  signed dot product.
- busy  out  1  partial vector in progress (beat_cnt != 0).

Behaviour:
- Reset (areset=0, asynchronous): acc=0, beat_cnt=0, out_valid=0, q=0, busy=0. Any partial vector is lost.
- Beat accept: in_valid && in_ready at a rising clk edge.
- Arithmetic:
  - Beat sum = sum over lanes of sign-extended a[i]*b[i] (full 2*DATA_W products), computed at ACC_W width.
  - No rounding; the accumulator never overflows for legal parameters.
- beat_cnt counts 0..BEATS-1, where BEATS = VEC_LEN/LANES.
- On accepted non-final beat: acc += beat_sum; beat_cnt += 1.
- On accepted final beat (beat_cnt == BEATS-1):
  - q <= convert(acc + beat_sum); out_valid <= 1.
  - acc <= 0; beat_cnt <= 0.
  - Latency: q/out_valid visible the cycle after the final beat is accepted.
  - BEATS == 1 degenerates to one result per beat.
- Output register: q and out_valid hold stable while out_valid && !out_ready. out_valid clears on out_valid && out_ready unless a new final beat is accepted the same cycle; in that case out_valid stays 1 and q takes the new value.
- in_ready = !(beat_cnt == BEATS-1 && out_valid && !out_ready). Non-final beats of the next vector are accepted while a result is pending; only the final beat stalls. in_ready does not depend on in_valid.
- clr:
  - clr=1 forces acc <= 0 and beat_cnt <= 0.
  - A beat presented in the same cycle is not accepted: in_ready is forced 0 while clr=1.
  - A pending q/out_valid is unaffected.
- convert() without the macro: low OUT_W bits of the ACC_W sum (two's-complement wrap).
- Stalls: in_valid=0 gaps between beats are allowed; state holds.

Optional Feature:
- Macro: SPM_VEC_SAT_EN.
- Defined: convert() saturates to the signed OUT_W range. Sum > 2^(OUT_W-1)-1 gives 2^(OUT_W-1)-1; sum < -2^(OUT_W-1) gives -2^(OUT_W-1). Adds output sat_flag (1 bit), registered with q, reset 0, high when the delivered q was clamped.
- Undefined: wrap truncation as above; no sat_flag port.

Test Plan (DATA_W=8, LANES=2, VEC_LEN=4, OUT_W=16, out_ready=1 unless stated):
- Basic: beats a=(3,4)/b=(5,6) then a=(-2,1)/b=(7,10) -> q=35 with out_valid=1 for exactly 1 cycle, one cycle after beat 2.
- Overflow: two beats of all elements 127 (sum 64516):
  - SPM_VEC_SAT_EN defined -> q=32767, sat_flag=1.
  - Undefined -> q=-1020 (0xFC04).
- Backpressure: out_ready=0 after the basic vector; next vector's beat 1 is accepted, in_ready=0 at its final beat. q stays 35 until out_ready=1; the next result follows 1 cycle after the final beat is accepted.
- Flush: beat a=(9,9)/b=(9,9), then clr=1 for 1 cycle, then the basic vector -> q=35 (flushed partial not included); busy=0 after clr.
- Reset mid-operation: areset=0 asynchronously after 1 beat and with a result pending -> out_valid, q, busy, in-progress state all 0 immediately. The basic vector after release -> q=35.
- Gapped input: basic vector with 3 idle cycles between beats -> q=35, no spurious out_valid.
